// File: rtl/tri_pkg.sv
// Shared constants, FSM encoding and min/max helpers for the triangle raster scan.
package tri_pkg;

  localparam int COORD_W = 11;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_BBOX  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // One slot of the checker-alignment pipe: a point and whether it was really issued.
  typedef struct packed {
    logic   issue;
    coord_t x;
    coord_t y;
  } pipe_ent_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_bbox.sv
// Combinational bounding box of three vertices, clamped to the visible screen.
module tri_bbox
  import tri_pkg::*;
(
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax,
  output logic               empty
);

  localparam coord_t X_LAST = coord_t'(H_RES - 1);
  localparam coord_t Y_LAST = coord_t'(V_RES - 1);

  coord_t xmax_raw;
  coord_t ymax_raw;

  always_comb begin
    xmin     = min3(ax, bx, cx);
    ymin     = min3(ay, by, cy);
    xmax_raw = max3(ax, bx, cx);
    ymax_raw = max3(ay, by, cy);
    xmax     = (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
    ymax     = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;
    // A box lying wholly past the right or bottom edge inverts after clamping.
    empty    = (xmin > xmax) || (ymin > ymax);
  end

endmodule

// File: rtl/triangle_raster_scan.sv
// Sweeps the clamped bounding box of a triangle one point per clock and realigns
// each point with the checker's delayed result to produce framebuffer writes.
module triangle_raster_scan
  import tri_pkg::*;
#(
  parameter int CHECK_LAT = 2,
  parameter bit EMIT_ALL  = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  input  logic               check,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_inside,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  // Handshake: start is a level request honoured only in IDLE; done is a single-cycle
  // pulse while busy is still high; pix_valid is a one-cycle strobe with no back-pressure.

  state_t state;
  state_t state_nx;

  coord_t ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  coord_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic   bb_empty;
  coord_t xmin_q, xmax_q, ymin_q, ymax_q;
  logic   empty_q;

  pipe_ent_t pipe_q [CHECK_LAT];
  pipe_ent_t tail;
  logic      issue;
  logic      pipe_empty;
  logic      last_point;

  tri_bbox u_bbox (
    .ax    (ax_q),
    .ay    (ay_q),
    .bx    (bx_q),
    .by    (by_q),
    .cx    (cx_q),
    .cy    (cy_q),
    .xmin  (bb_xmin),
    .xmax  (bb_xmax),
    .ymin  (bb_ymin),
    .ymax  (bb_ymax),
    .empty (bb_empty)
  );

  assign last_point = (px == xmax_q) && (py == ymax_q);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_BBOX;
      ST_BBOX:  state_nx = empty_q ? ST_DRAIN : ST_SCAN;
      ST_SCAN:  if (last_point) state_nx = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    issue     = (state == ST_SCAN);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DRAIN) && pipe_empty;
    dbg_state = state;
  end

  // Vertex capture, box registration and the raster walk (x fastest).
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      empty_q <= 1'b0;
      px      <= '0;
      py      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ax_q <= ax;
            ay_q <= ay;
            bx_q <= bx;
            by_q <= by;
            cx_q <= cx;
            cy_q <= cy;
          end
        end
        ST_LATCH: begin
          xmin_q  <= bb_xmin;
          xmax_q  <= bb_xmax;
          ymin_q  <= bb_ymin;
          ymax_q  <= bb_ymax;
          empty_q <= bb_empty;
        end
        ST_BBOX: begin
          if (!empty_q) begin
            px <= xmin_q;
            py <= ymin_q;
          end
        end
        ST_SCAN: begin
          // At the final point px/py are left alone so they hold after the scan.
          if (px != xmax_q) begin
            px <= px + coord_t'(1);
          end else if (py != ymax_q) begin
            px <= xmin_q;
            py <= py + coord_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHECK_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {issue, px, py};
      for (int i = 1; i < CHECK_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < CHECK_LAT; i++) begin
      if (pipe_q[i].issue) pipe_empty = 1'b0;
    end
  end

  // The tail of the pipe lines up with the checker's answer for the same point.
  assign tail       = pipe_q[CHECK_LAT-1];
  assign pix_valid  = tail.issue & (EMIT_ALL | check);
  assign pix_inside = tail.issue & check;
  assign pix_x      = tail.x;
  assign pix_y      = tail.y;

endmodule
